glitch_param_programmer: RTL

GLITCH_PARAM_PROGRAMMER -- requirements
Module: glitch_param_programmer

---
 rtl/glitch_prog_pkg.sv | 23 ++
 rtl/glitch_prog_if.sv | 27 ++
 rtl/glitch_prog_tick.sv | 43 ++++
 rtl/glitch_param_programmer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/glitch_prog_pkg.sv
// glitch_prog_pkg -- shared constants and types for the glitch parameter programmer.
//   TARGET_W_DEFAULT    : default width of one glitch target
//   SEL_IO / SEL_CLK    : target select encoding carried in the select beat
//   DEFAULT_*_TARGET    : receiver/shadow values after reset
//   state_e             : serialiser FSM state encoding
package glitch_prog_pkg;

  localparam int unsigned TARGET_W_DEFAULT   = 33;
  localparam logic        SEL_IO             = 1'b1;
  localparam logic        SEL_CLK            = 1'b0;
  localparam int unsigned DEFAULT_IO_TARGET  = 720;
  localparam int unsigned DEFAULT_CLK_TARGET = 13255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL_LO = 3'd1,
    ST_SEL_HI = 3'd2,
    ST_BIT_LO = 3'd3,
    ST_BIT_HI = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/glitch_prog_if.sv
// glitch_prog_if -- host request and serial programming bus.
//   start/sel/value : host -> programmer request (sampled together)
//   busy/done       : programmer status
//   prog_clk/prog_reset/prog_io : serial frame towards the glitch trigger
// Modports: master = host side, slave = programmer side.
interface glitch_prog_if #(
  parameter int unsigned TARGET_W = 33
);
  logic                start;
  logic                sel;
  logic [TARGET_W-1:0] value;
  logic                busy;
  logic                done;
  logic                prog_clk;
  logic                prog_reset;
  logic                prog_io;

  modport master (
    output start, sel, value,
    input  busy, done, prog_clk, prog_reset, prog_io
  );

  modport slave (
    input  start, sel, value,
    output busy, done, prog_clk, prog_reset, prog_io
  );
endinterface

// File: rtl/glitch_prog_tick.sv
// glitch_prog_tick -- phase timer; phase_end pulses in the last cycle of each
// HALF_PERIOD-cycle phase.
//   clk, rst   : clock, asynchronous active-high reset
//   restart    : hold the count at zero (next phase starts fresh)
//   phase_end  : one-cycle pulse, last cycle of the current phase
module glitch_prog_tick #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_end
);

  localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // next count: cleared on restart, wraps at the end of each phase
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = 8'd0;
    end else if (cnt_q == LAST) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign phase_end = !restart && (cnt_q == LAST);

  // phase counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/glitch_param_programmer.sv
// glitch_param_programmer -- serialises one glitch target per start request.
// A frame is one select beat (prog_reset=0, prog_io=sel) followed by TARGET_W
// data beats (prog_reset=1, MSB first); each beat is a LO then HI phase of
// HALF_PERIOD host clocks. Data is changed only on LO entry.
//   host_clk, host_reset : clock, asynchronous active-high reset
//   bus (slave)          : start/sel/value in, busy/done/prog_* out
//   io_target_q, clk_target_q : local copies of the programmed targets,
//                          present only when GLITCH_PROG_SHADOW_EN is defined
module glitch_param_programmer
  import glitch_prog_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned TARGET_W    = TARGET_W_DEFAULT
) (
  input  logic                host_clk,
  input  logic                host_reset,
  glitch_prog_if.slave        bus
`ifdef GLITCH_PROG_SHADOW_EN
  ,
  output logic [TARGET_W-1:0] io_target_q,
  output logic [TARGET_W-1:0] clk_target_q
`endif
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] SEL_LO = ST_SEL_LO;
  localparam logic [2:0] SEL_HI = ST_SEL_HI;
  localparam logic [2:0] BIT_LO = ST_BIT_LO;
  localparam logic [2:0] BIT_HI = ST_BIT_HI;
  localparam logic [2:0] DONE   = ST_DONE;

  localparam int unsigned      CNT_W     = $clog2(TARGET_W + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TARGET_W - 1);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  // Rotated left once per data beat; after TARGET_W beats it equals the
  // latched value again, so no separate copy is needed for the shadows.
  logic [TARGET_W-1:0] data_q, data_d;
  logic                prog_clk_q, prog_clk_d;
  logic                prog_reset_q, prog_reset_d;
  logic                prog_io_q, prog_io_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                phase_end;
  logic                tick_restart;

  assign tick_restart = (state_q == IDLE) || (state_q == DONE);

  glitch_prog_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk       (host_clk),
    .rst       (host_reset),
    .restart   (tick_restart),
    .phase_end (phase_end)
  );

  // FSM next state and registered outputs, computed together so that outputs
  // change on the same edge as the state
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    data_d       = data_q;
    prog_clk_d   = prog_clk_q;
    prog_reset_d = prog_reset_q;
    prog_io_d    = prog_io_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = SEL_LO;
          data_d       = bus.value;
          beat_d       = '0;
          prog_clk_d   = 1'b0;
          prog_reset_d = 1'b0;
          prog_io_d    = bus.sel;
          busy_d       = 1'b1;
        end else begin
          prog_clk_d   = 1'b0;
          prog_reset_d = 1'b0;
          prog_io_d    = 1'b0;
          busy_d       = 1'b0;
        end
      end
      SEL_LO, BIT_LO: begin
        if (phase_end) begin
          state_d    = (state_q == SEL_LO) ? SEL_HI : BIT_HI;
          prog_clk_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      SEL_HI: begin
        if (phase_end) begin
          state_d      = BIT_LO;
          prog_clk_d   = 1'b0;
          prog_reset_d = 1'b1;
          prog_io_d    = data_q[TARGET_W-1];
          data_d       = {data_q[TARGET_W-2:0], data_q[TARGET_W-1]};
        end else begin
          state_d = state_q;
        end
      end
      BIT_HI: begin
        if (phase_end && (beat_q == LAST_BEAT)) begin
          state_d      = DONE;
          prog_clk_d   = 1'b0;
          prog_reset_d = 1'b0;
          prog_io_d    = 1'b0;
          done_d       = 1'b1;
        end else if (phase_end) begin
          state_d    = BIT_LO;
          beat_d     = beat_q + CNT_W'(1);
          prog_clk_d = 1'b0;
          prog_io_d  = data_q[TARGET_W-1];
          data_d     = {data_q[TARGET_W-2:0], data_q[TARGET_W-1]};
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        prog_clk_d   = 1'b0;
        prog_reset_d = 1'b0;
        prog_io_d    = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // FSM, beat counter, data and output registers
  always_ff @(posedge host_clk or posedge host_reset) begin
    if (host_reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      data_q       <= '0;
      prog_clk_q   <= 1'b0;
      prog_reset_q <= 1'b0;
      prog_io_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      data_q       <= data_d;
      prog_clk_q   <= prog_clk_d;
      prog_reset_q <= prog_reset_d;
      prog_io_q    <= prog_io_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.prog_clk   = prog_clk_q;
  assign bus.prog_reset = prog_reset_q;
  assign bus.prog_io    = prog_io_q;

`ifdef GLITCH_PROG_SHADOW_EN
  logic                sel_q, sel_d;
  logic [TARGET_W-1:0] io_target_d;
  logic [TARGET_W-1:0] clk_target_d;

  // shadow next values: select latched with start, target loaded on DONE entry
  always_comb begin
    sel_d        = sel_q;
    io_target_d  = io_target_q;
    clk_target_d = clk_target_q;
    if ((state_q == IDLE) && bus.start) begin
      sel_d = bus.sel;
    end else begin
      sel_d = sel_q;
    end
    if ((state_d == DONE) && (state_q != DONE)) begin
      if (sel_q == SEL_IO) begin
        io_target_d = data_q;
      end else begin
        clk_target_d = data_q;
      end
    end else begin
      io_target_d  = io_target_q;
      clk_target_d = clk_target_q;
    end
  end

  // shadow registers
  always_ff @(posedge host_clk or posedge host_reset) begin
    if (host_reset) begin
      sel_q        <= SEL_CLK;
      io_target_q  <= TARGET_W'(DEFAULT_IO_TARGET);
      clk_target_q <= TARGET_W'(DEFAULT_CLK_TARGET);
    end else begin
      sel_q        <= sel_d;
      io_target_q  <= io_target_d;
      clk_target_q <= clk_target_d;
    end
  end
`endif

endmodule
